// File: rtl/word_finder_pkg.sv
// Shared types, constants and the case-fold helper for the dictionary word finder.
package FS1;

  typedef enum logic [3:0] {
    IDLE,
    SKIP,
    SCAN,
    LNK_LO,
    LNK_HI,
    LEN,
    CMP,
    OPC,
    DONE
  } finder_state_e;

  localparam logic [15:0] LFA_NULL = 16'hFFFF;
  localparam int unsigned TOK_MAX  = 31;
  localparam logic [7:0]  CH_SPACE = 8'h20;
  localparam logic [7:0]  CH_NUL   = 8'h00;

  function automatic logic [7:0] fold_lc(input logic [7:0] c);
    fold_lc = ((c >= 8'h41) && (c <= 8'h5A)) ? (c | 8'h20) : c;
  endfunction

endpackage

// File: rtl/word_finder_if.sv
// Byte-wide synchronous memory bus: address/write-enable out, read data back one cycle later.
interface mb8_io #(
  parameter int unsigned ASZ = 17,
  parameter int unsigned DSZ = 8
);
  logic [ASZ-1:0] ai;
  logic           we;
  logic [DSZ-1:0] vo;

  modport master (output ai, output we, input vo);
  modport slave  (input ai, input we, output vo);
endinterface

// File: rtl/word_finder.sv
// Parses the next blank-delimited token from the TIB and walks the linked dictionary for it.
// Define FINDER_NOCASE_EN to fold 'A'-'Z' to lower case when comparing names.
module word_finder
  import FS1::*;
#(
  parameter int unsigned TIB = 'h0,
  parameter int unsigned DSZ = 8,
  parameter int unsigned ASZ = 17
) (
  input  logic           clk,
  input  logic           rst,
  mb8_io.master          b8_if,
  input  logic           start,
  input  logic [ASZ-1:0] tib_in,
  input  logic [ASZ-1:0] ctx,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic           eot,
  output logic [ASZ-1:0] pfa,
  output logic [7:0]     op,
  output logic [4:0]     tok_len,
  output logic [ASZ-1:0] tib_nxt
);

  localparam logic [ASZ-1:0] TIB_A  = ASZ'(TIB);
  localparam logic [ASZ-1:0] NULL_A = ASZ'(LFA_NULL);

  finder_state_e  state_q, state_d;
  logic [ASZ-1:0] tp_q, tp_d;
  logic           vld_q, vld_d;
  logic [ASZ-1:0] lfa_q, lfa_d;
  logic [ASZ-1:0] ctx_q, ctx_d;
  logic [DSZ-1:0] lo_q, lo_d;
  logic [DSZ-1:0] hi_q, hi_d;
  logic [4:0]     idx_q, idx_d;
  logic           ovf_q, ovf_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           found_q, found_d;
  logic           eot_q, eot_d;
  logic [ASZ-1:0] pfa_q, pfa_d;
  logic [7:0]     op_q, op_d;
  logic [4:0]     tok_len_q, tok_len_d;
  logic [ASZ-1:0] tib_nxt_q, tib_nxt_d;

  logic [DSZ-1:0] tbuf_q [0:TOK_MAX];
  logic           buf_we;
  logic [4:0]     buf_idx;

  logic [ASZ-1:0] ai_c;
  logic [ASZ-1:0] link_c;
  logic [ASZ-1:0] name_base;
  logic           link_null;
  logic           follow;
  logic [7:0]     name_c;
  logic [7:0]     tok_c;

  assign link_c    = ASZ'({hi_q, lo_q});
  assign link_null = ({hi_q, lo_q} == LFA_NULL);
  assign name_base = lfa_q + ASZ'(3);

`ifdef FINDER_NOCASE_EN
  assign name_c = fold_lc(b8_if.vo);
  assign tok_c  = fold_lc(tbuf_q[idx_q]);
`else
  assign name_c = b8_if.vo;
  assign tok_c  = tbuf_q[idx_q];
`endif

  // ai is decided from the byte arriving this cycle so the next byte lands one cycle later;
  // that keeps a length mismatch at 3 cycles per entry with a single-port memory.
  always_comb begin
    state_d   = state_q;
    tp_d      = tp_q;
    vld_d     = vld_q;
    lfa_d     = lfa_q;
    ctx_d     = ctx_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    idx_d     = idx_q;
    ovf_d     = ovf_q;
    found_d   = found_q;
    eot_d     = eot_q;
    pfa_d     = pfa_q;
    op_d      = op_q;
    tok_len_d = tok_len_q;
    tib_nxt_d = tib_nxt_q;
    ai_c      = tp_q;
    buf_we    = 1'b0;
    buf_idx   = tok_len_q;
    follow    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SKIP;
          tp_d      = tib_in;
          ctx_d     = ctx;
          vld_d     = 1'b0;
          ovf_d     = 1'b0;
          found_d   = 1'b0;
          eot_d     = 1'b0;
          pfa_d     = '0;
          op_d      = '0;
          tok_len_d = '0;
        end
      end

      SKIP: begin
        if (!vld_q) begin
          vld_d = 1'b1;
        end else if (b8_if.vo == CH_SPACE) begin
          tp_d = tp_q + ASZ'(1);
          ai_c = tp_q + ASZ'(1);
        end else if (b8_if.vo == CH_NUL) begin
          eot_d     = 1'b1;
          tib_nxt_d = tp_q;
          state_d   = DONE;
        end else begin
          buf_we    = 1'b1;
          buf_idx   = '0;
          tok_len_d = 5'd1;
          tp_d      = tp_q + ASZ'(1);
          ai_c      = tp_q + ASZ'(1);
          state_d   = SCAN;
        end
      end

      SCAN: begin
        if ((b8_if.vo == CH_SPACE) || (b8_if.vo == CH_NUL)) begin
          tib_nxt_d = tp_q;
          if (ovf_q || (ctx_q == NULL_A)) begin
            state_d = DONE;
          end else begin
            lfa_d   = ctx_q;
            ai_c    = ctx_q;
            state_d = LNK_LO;
          end
        end else begin
          if (tok_len_q == 5'(TOK_MAX)) begin
            ovf_d = 1'b1;
          end else begin
            buf_we    = 1'b1;
            tok_len_d = tok_len_q + 5'd1;
          end
          tp_d = tp_q + ASZ'(1);
          ai_c = tp_q + ASZ'(1);
        end
      end

      LNK_LO: begin
        lo_d    = b8_if.vo;
        ai_c    = lfa_q + ASZ'(1);
        state_d = LNK_HI;
      end

      LNK_HI: begin
        hi_d    = b8_if.vo;
        ai_c    = lfa_q + ASZ'(2);
        state_d = LEN;
      end

      LEN: begin
        if (b8_if.vo == DSZ'(tok_len_q)) begin
          idx_d   = '0;
          ai_c    = name_base;
          state_d = CMP;
        end else begin
          follow = 1'b1;
        end
      end

      CMP: begin
        if (name_c != tok_c) begin
          follow = 1'b1;
        end else if (idx_q == (tok_len_q - 5'd1)) begin
          ai_c    = name_base + ASZ'(tok_len_q);
          state_d = OPC;
        end else begin
          idx_d = idx_q + 5'd1;
          ai_c  = name_base + ASZ'(idx_q) + ASZ'(1);
        end
      end

      OPC: begin
        pfa_d   = name_base + ASZ'(tok_len_q);
        op_d    = b8_if.vo;
        found_d = 1'b1;
        state_d = DONE;
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    if (follow) begin
      if (link_null) begin
        state_d = DONE;
      end else begin
        lfa_d   = link_c;
        ai_c    = link_c;
        state_d = LNK_LO;
      end
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      tp_q      <= TIB_A;
      vld_q     <= 1'b0;
      lfa_q     <= '0;
      ctx_q     <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      eot_q     <= 1'b0;
      pfa_q     <= '0;
      op_q      <= '0;
      tok_len_q <= '0;
      tib_nxt_q <= TIB_A;
    end else begin
      state_q   <= state_d;
      tp_q      <= tp_d;
      vld_q     <= vld_d;
      lfa_q     <= lfa_d;
      ctx_q     <= ctx_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      found_q   <= found_d;
      eot_q     <= eot_d;
      pfa_q     <= pfa_d;
      op_q      <= op_d;
      tok_len_q <= tok_len_d;
      tib_nxt_q <= tib_nxt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) begin
      tbuf_q[buf_idx] <= b8_if.vo;
    end
  end

  assign b8_if.ai = ai_c;
  assign b8_if.we = 1'b0;

  assign busy    = busy_q;
  assign done    = done_q;
  assign found   = found_q;
  assign eot     = eot_q;
  assign pfa     = pfa_q;
  assign op      = op_q;
  assign tok_len = tok_len_q;
  assign tib_nxt = tib_nxt_q;

endmodule

// File: tb/tb_word_finder.sv
// Directed self-checking bench for word_finder with a behavioural one-cycle-latency memory.
module tb_word_finder;

  localparam int unsigned ASZ  = 17;
  localparam int unsigned TIBP = 'h3C;
  localparam logic [ASZ-1:0] CTX = 'h123;
  localparam logic [7:0] OP_NOP = 8'h01, OP_DUP = 8'h10, OP_DROP = 8'h11;
  localparam logic [7:0] OP_SWAP = 8'h12, OP_PLUS = 8'h20, OP_MINUS = 8'h21;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [ASZ-1:0] tib_in = '0;
  logic [ASZ-1:0] ctx = '0;
  logic           busy, done, found, eot;
  logic [ASZ-1:0] pfa, tib_nxt;
  logic [7:0]     op;
  logic [4:0]     tok_len;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:(1<<ASZ)-1];

  mb8_io #(.ASZ(ASZ), .DSZ(8)) b8_if ();

  word_finder #(.TIB(TIBP), .DSZ(8), .ASZ(ASZ)) dut (
    .clk     (clk),
    .rst     (rst),
    .b8_if   (b8_if),
    .start   (start),
    .tib_in  (tib_in),
    .ctx     (ctx),
    .busy    (busy),
    .done    (done),
    .found   (found),
    .eot     (eot),
    .pfa     (pfa),
    .op      (op),
    .tok_len (tok_len),
    .tib_nxt (tib_nxt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) b8_if.vo <= mem[b8_if.ai];

  task automatic put_str(input logic [ASZ-1:0] a, input string s);
    for (int i = 0; i < s.len(); i++) mem[a + ASZ'(i)] = s[i];
  endtask

  task automatic put_entry(input logic [ASZ-1:0] lfa, input logic [15:0] link,
                           input string nm, input logic [7:0] opc);
    mem[lfa]          = link[7:0];
    mem[lfa + 17'd1]  = link[15:8];
    mem[lfa + 17'd2]  = 8'(nm.len());
    put_str(lfa + 17'd3, nm);
    mem[lfa + 17'd3 + ASZ'(nm.len())] = opc;
  endtask

  // Launch one lookup; k is the cycle index (accept cycle = 0) in which done is seen.
  task automatic run_find(input logic [ASZ-1:0] t, output int k, output bit ok,
                          output bit pulse_ok);
    @(negedge clk);
    start  = 1'b1;
    tib_in = t;
    ctx    = CTX;
    @(posedge clk);
    #1 start = 1'b0;
    k  = 1;
    ok = 1'b0;
    pulse_ok = 1'b0;
    while (k < 3000) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1 k++;
    end
    if (ok) begin
      @(posedge clk);
      #1 pulse_ok = !done;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, found, eot} !== 4'b0)
      begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, found, eot}); end
    checks++;
    if (pfa !== '0 || op !== 8'h0 || tok_len !== 5'd0)
      begin errors++; $display("FAIL reset_res: got pfa=%0h op=%0h len=%0d want 0 0 0", pfa, op, tok_len); end
    checks++;
    if (tib_nxt !== ASZ'(TIBP))
      begin errors++; $display("FAIL reset_tib_nxt: got %0h want %0h", tib_nxt, TIBP); end
    checks++;
    if (b8_if.ai !== ASZ'(TIBP) || b8_if.we !== 1'b0)
      begin errors++; $display("FAIL reset_bus: got ai=%0h we=%b want %0h 0", b8_if.ai, b8_if.we, TIBP); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_dup;
    int k; bit ok, pulse_ok;
    run_find('h0, k, ok, pulse_ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL dup_timeout: got no done want done"); end
    checks++;
    if (found !== 1'b1 || eot !== 1'b0)
      begin errors++; $display("FAIL dup_found: got found=%b eot=%b want 1 0", found, eot); end
    checks++;
    if (pfa !== 'h10D || op !== OP_DUP)
      begin errors++; $display("FAIL dup_pfa: got pfa=%0h op=%0h want 10d %0h", pfa, op, OP_DUP); end
    checks++;
    if (tok_len !== 5'd3 || tib_nxt !== 'h5)
      begin errors++; $display("FAIL dup_tok: got len=%0d nxt=%0h want 3 5", tok_len, tib_nxt); end
    checks++;
    if (k !== 27) begin errors++; $display("FAIL dup_cycles: got %0d want 27", k); end
    checks++;
    if (!pulse_ok) begin errors++; $display("FAIL dup_pulse: got done>1 cycle want 1 cycle"); end
    checks++;
    if (found !== 1'b1 || pfa !== 'h10D)
      begin errors++; $display("FAIL dup_hold: got found=%b pfa=%0h want 1 10d", found, pfa); end
  endtask

  task automatic test_back_to_back;
    int k; bit ok, pulse_ok;
    run_find('h5, k, ok, pulse_ok);
    checks++;
    if (!ok || found !== 1'b1 || pfa !== 'h11D || op !== OP_SWAP || tib_nxt !== 'hA || tok_len !== 5'd4)
      begin errors++; $display("FAIL swap: got ok=%b f=%b pfa=%0h op=%0h nxt=%0h len=%0d want 1 1 11d %0h a 4",
                               ok, found, pfa, op, tib_nxt, tok_len, OP_SWAP); end
    run_find('hA, k, ok, pulse_ok);
    checks++;
    if (!ok || found !== 1'b1 || pfa !== 'h122 || op !== OP_PLUS || tib_nxt !== 'hC || tok_len !== 5'd1)
      begin errors++; $display("FAIL plus: got ok=%b f=%b pfa=%0h op=%0h nxt=%0h len=%0d want 1 1 122 %0h c 1",
                               ok, found, pfa, op, tib_nxt, tok_len, OP_PLUS); end
  endtask

  task automatic test_eot;
    int k; bit ok, pulse_ok;
    run_find('hC, k, ok, pulse_ok);
    checks++;
    if (!ok || eot !== 1'b1 || found !== 1'b0)
      begin errors++; $display("FAIL eot_flags: got ok=%b eot=%b found=%b want 1 1 0", ok, eot, found); end
    checks++;
    if (tib_nxt !== 'hC || tok_len !== 5'd0)
      begin errors++; $display("FAIL eot_tok: got nxt=%0h len=%0d want c 0", tib_nxt, tok_len); end
    checks++;
    if (k !== 3) begin errors++; $display("FAIL eot_cycles: got %0d want 3", k); end
  endtask

  task automatic test_case;
    int k; bit ok, pulse_ok;
    logic exp_found;
    logic [ASZ-1:0] exp_pfa;
`ifdef FINDER_NOCASE_EN
    exp_found = 1'b1;
    exp_pfa   = 'h10D;
`else
    exp_found = 1'b0;
    exp_pfa   = '0;
`endif
    run_find('h200, k, ok, pulse_ok);
    checks++;
    if (!ok || found !== exp_found || pfa !== exp_pfa || tib_nxt !== 'h203)
      begin errors++; $display("FAIL case_fold: got ok=%b f=%b pfa=%0h nxt=%0h want 1 %b %0h 203",
                               ok, found, pfa, tib_nxt, exp_found, exp_pfa); end
  endtask

  task automatic test_no_match;
    int k; bit ok, pulse_ok;
    run_find('h210, k, ok, pulse_ok);
    checks++;
    if (!ok || found !== 1'b0 || eot !== 1'b0 || tok_len !== 5'd4 || tib_nxt !== 'h214)
      begin errors++; $display("FAIL dupx: got ok=%b f=%b eot=%b len=%0d nxt=%0h want 1 0 0 4 214",
                               ok, found, eot, tok_len, tib_nxt); end
  endtask

  task automatic test_overflow;
    int k; bit ok, pulse_ok;
    run_find('h220, k, ok, pulse_ok);
    checks++;
    if (!ok || found !== 1'b0 || eot !== 1'b0)
      begin errors++; $display("FAIL ovf_flags: got ok=%b f=%b eot=%b want 1 0 0", ok, found, eot); end
    checks++;
    if (tok_len !== 5'd31 || tib_nxt !== 'h241)
      begin errors++; $display("FAIL ovf_tok: got len=%0d nxt=%0h want 31 241", tok_len, tib_nxt); end
  endtask

  task automatic test_busy_ignore;
    bit ok;
    @(negedge clk);
    start = 1'b1; tib_in = 'h0; ctx = CTX;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_high: got %b want 1", busy); end
    repeat (4) @(negedge clk);
    start = 1'b1; tib_in = 'h5;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (done) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok || pfa !== 'h10D || tib_nxt !== 'h5)
      begin errors++; $display("FAIL busy_ignore: got ok=%b pfa=%0h nxt=%0h want 1 10d 5", ok, pfa, tib_nxt); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort;
    int k; bit ok, pulse_ok, seen;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1; tib_in = 'h0; ctx = CTX;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, found, eot} !== 4'b0 || tok_len !== 5'd0 || pfa !== '0 || op !== 8'h0)
      begin errors++; $display("FAIL abort_res: got flags=%b len=%0d pfa=%0h op=%0h want 0000 0 0 0",
                               {busy, done, found, eot}, tok_len, pfa, op); end
    checks++;
    if (tib_nxt !== ASZ'(TIBP) || b8_if.ai !== ASZ'(TIBP))
      begin errors++; $display("FAIL abort_ptr: got nxt=%0h ai=%0h want %0h", tib_nxt, b8_if.ai, TIBP); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL abort_done: got done pulse want none"); end
    run_find('h0, k, ok, pulse_ok);
    checks++;
    if (!ok || found !== 1'b1 || pfa !== 'h10D || op !== OP_DUP || k !== 27)
      begin errors++; $display("FAIL abort_rerun: got ok=%b f=%b pfa=%0h op=%0h k=%0d want 1 1 10d %0h 27",
                               ok, found, pfa, op, k, OP_DUP); end
  endtask

  initial begin
    for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'h00;
    put_entry('h100, 16'hFFFF, "nop",  OP_NOP);
    put_entry('h107, 16'h0100, "dup",  OP_DUP);
    put_entry('h10E, 16'h0107, "drop", OP_DROP);
    put_entry('h116, 16'h010E, "swap", OP_SWAP);
    put_entry('h11E, 16'h0116, "+",    OP_PLUS);
    put_entry('h123, 16'h011E, "-",    OP_MINUS);
    put_str('h0,   "  dup swap +");
    put_str('h200, "DUP");
    put_str('h210, "dupx");
    for (int i = 0; i < 33; i++) mem['h220 + i] = 8'h61;
    mem['h241] = 8'h20;

    test_reset();
    test_dup();
    test_back_to_back();
    test_eot();
    test_case();
    test_no_match();
    test_overflow();
    test_busy_ignore();
    test_reset_abort();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
